// File: rtl/note_recorder.sv
// note_recorder: record/playback stage ahead of the piano note mux.
// Recording turns the live note stream into run-length {note, duration}
// entries, with durations counted in quarter-beat ticks. Playback drives
// those entries back out on note_out using the same tick.
// Optional feature macro: NOTE_RECORDER_LOOP_EN. When it is defined,
// playback wraps to entry 0 and keeps going until a STOP edge.
module note_recorder #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DUR_W  = 6
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REC,
  input  logic              PLAY,
  input  logic              STOP,
  input  logic              QUARTER_BEAT,
  input  logic [3:0]        note_in,
  output logic [3:0]        note_out,
  output logic              recording,
  output logic              playing,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam logic [1:0]        ST_IDLE     = 2'd0;
  localparam logic [1:0]        ST_REC      = 2'd1;
  localparam logic [1:0]        ST_PLAY     = 2'd2;
  localparam int                ENT_W       = 4 + DUR_W;
  localparam logic [3:0]        NOTE_SILENT = 4'b1111;
  localparam logic [DUR_W-1:0]  DUR_ZERO    = {DUR_W{1'b0}};
  localparam logic [DUR_W-1:0]  DUR_ONE     = {{(DUR_W-1){1'b0}}, 1'b1};
  localparam logic [DUR_W-1:0]  DUR_MAX     = {DUR_W{1'b1}};
  localparam logic [ADDR_W-1:0] IDX_ZERO    = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO    = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL    = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state_r;
  logic [3:0]        note_out_r;
  logic [3:0]        cur_note_r;
  logic              recording_r;
  logic              playing_r;
  logic              full_r;
  logic              load_pend_r;
  logic [ADDR_W:0]   count_r;
  logic [DUR_W-1:0]  dur_r;
  logic [DUR_W-1:0]  remain_r;
  logic [ADDR_W-1:0] rd_idx_r;
  logic              qb_d_r;
  logic              rec_d_r;
  logic              play_d_r;
  logic              stop_d_r;
  logic [ENT_W-1:0]  mem_r [DEPTH];

  logic              tick_s;
  logic              rec_e_s;
  logic              play_e_s;
  logic              stop_e_s;
  logic              note_chg_s;
  logic              dur_sat_s;
  logic              wr_en_s;
  logic              last_s;
  logic [ADDR_W:0]   count_inc_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [ENT_W-1:0]  rd_ent_s;
  logic [3:0]        rd_note_s;
  logic [DUR_W-1:0]  rd_dur_s;

  assign note_out  = note_out_r;
  assign recording = recording_r;
  assign playing   = playing_r;
  assign full      = full_r;
  assign count     = count_r;

  // Rising-edge strobes for the tick and the three command levels.
  always_comb begin
    tick_s   = QUARTER_BEAT & ~qb_d_r;
    rec_e_s  = REC & ~rec_d_r;
    play_e_s = PLAY & ~play_d_r;
    stop_e_s = STOP & ~stop_d_r;
  end

  // Segment bookkeeping: a write closes the current segment on a note change,
  // on a saturated duration, or on STOP; zero-tick segments are never written.
  always_comb begin
    note_chg_s  = (note_in != cur_note_r);
    dur_sat_s   = (dur_r == DUR_MAX);
    count_inc_s = count_r + CNT_ONE;
    if (state_r == ST_REC) begin
      if (stop_e_s) begin
        wr_en_s = (dur_r != DUR_ZERO) && !full_r;
      end else begin
        wr_en_s = (note_chg_s && (dur_r != DUR_ZERO)) || dur_sat_s;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Combinational read port; entry 0 is presented while idle so PLAY can load it.
  always_comb begin
    if (state_r == ST_PLAY) begin
      rd_addr_s = rd_idx_r;
    end else begin
      rd_addr_s = IDX_ZERO;
    end
    rd_ent_s  = mem_r[rd_addr_s];
    rd_note_s = rd_ent_s[ENT_W-1:DUR_W];
    rd_dur_s  = rd_ent_s[DUR_W-1:0];
    last_s    = ({1'b0, rd_idx_r} == (count_r - CNT_ONE));
  end

  // Entry buffer: synchronous write at the current count, contents not reset.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_r[count_r[ADDR_W-1:0]] <= {cur_note_r, dur_r};
    end
  end

  // Control FSM, edge-detect history and all registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      note_out_r  <= NOTE_SILENT;
      cur_note_r  <= 4'd0;
      recording_r <= 1'b0;
      playing_r   <= 1'b0;
      full_r      <= 1'b0;
      load_pend_r <= 1'b0;
      count_r     <= CNT_ZERO;
      dur_r       <= DUR_ZERO;
      remain_r    <= DUR_ZERO;
      rd_idx_r    <= IDX_ZERO;
      qb_d_r      <= 1'b0;
      rec_d_r     <= 1'b0;
      play_d_r    <= 1'b0;
      stop_d_r    <= 1'b0;
    end else begin
      qb_d_r   <= QUARTER_BEAT;
      rec_d_r  <= REC;
      play_d_r <= PLAY;
      stop_d_r <= STOP;
      case (state_r)
        ST_IDLE: begin
          note_out_r <= note_in;
          if (stop_e_s) begin
            state_r <= ST_IDLE;
          end else if (rec_e_s) begin
            state_r     <= ST_REC;
            recording_r <= 1'b1;
            count_r     <= CNT_ZERO;
            full_r      <= 1'b0;
            cur_note_r  <= note_in;
            dur_r       <= DUR_ZERO;
          end else if (play_e_s && (count_r != CNT_ZERO)) begin
            state_r     <= ST_PLAY;
            playing_r   <= 1'b1;
            rd_idx_r    <= IDX_ZERO;
            load_pend_r <= 1'b0;
            note_out_r  <= rd_note_s;
            remain_r    <= rd_dur_s;
          end
        end
        ST_REC: begin
          note_out_r <= note_in;
          if (stop_e_s) begin
            if (wr_en_s) begin
              count_r <= count_inc_s;
              full_r  <= (count_inc_s == CNT_FULL);
            end
            state_r     <= ST_IDLE;
            recording_r <= 1'b0;
          end else if (wr_en_s) begin
            // A tick in the write cycle belongs to the segment that starts now.
            count_r    <= count_inc_s;
            cur_note_r <= note_in;
            dur_r      <= tick_s ? DUR_ONE : DUR_ZERO;
            if (count_inc_s == CNT_FULL) begin
              full_r      <= 1'b1;
              state_r     <= ST_IDLE;
              recording_r <= 1'b0;
            end
          end else if (note_chg_s) begin
            cur_note_r <= note_in;
            dur_r      <= tick_s ? DUR_ONE : DUR_ZERO;
          end else if (tick_s && !dur_sat_s) begin
            dur_r <= dur_r + DUR_ONE;
          end
        end
        ST_PLAY: begin
          if (stop_e_s) begin
            note_out_r  <= NOTE_SILENT;
            state_r     <= ST_IDLE;
            playing_r   <= 1'b0;
            load_pend_r <= 1'b0;
          end else if (load_pend_r) begin
            note_out_r  <= rd_note_s;
            remain_r    <= rd_dur_s;
            load_pend_r <= 1'b0;
          end else if (tick_s) begin
            if (remain_r <= DUR_ONE) begin
              if (last_s) begin
`ifdef NOTE_RECORDER_LOOP_EN
                rd_idx_r    <= IDX_ZERO;
                load_pend_r <= 1'b1;
`else
                note_out_r  <= NOTE_SILENT;
                state_r     <= ST_IDLE;
                playing_r   <= 1'b0;
`endif
              end else begin
                rd_idx_r    <= rd_idx_r + IDX_ONE;
                load_pend_r <= 1'b1;
              end
            end else begin
              remain_r <= remain_r - DUR_ONE;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          note_out_r  <= NOTE_SILENT;
          recording_r <= 1'b0;
          playing_r   <= 1'b0;
          load_pend_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
